imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory address width (32 entries).
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-state-machine fetch request, bit i = requester i.
REQ-006 SHALL have port req_addr  input  4*ADDR_W  fetch addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have port gnt  output  4  one-hot grant for the current cycle.
REQ-008 SHALL have port rvalid  output  4  one-hot, marks mem_rdata as valid for requester i.
REQ-009 SHALL have port rdata  output  DATA_W  fetched instruction broadcast to all requesters.
REQ-010 SHALL have ports host_we input 1, host_addr input ADDR_W, host_wdata input DATA_W: program-load write port.
REQ-011 SHALL have ports mem_read_addr output ADDR_W, mem_write_addr output ADDR_W, mem_data_in output DATA_W, mem_write_en output 1: instruction-regfile port.
REQ-012 SHALL have port mem_rdata  input  DATA_W  regfile read data, valid one cycle after mem_read_addr.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt is combinational from req, host_we and rr_ptr.
REQ-014 SHALL pick the winner round-robin: first asserted req[i] searching rr_ptr, rr_ptr+1, ... mod 4.
REQ-015 SHALL load rr_ptr with (winner+1) mod 4 on each edge where a grant is issued; rr_ptr holds otherwise.
REQ-016 SHALL drive mem_read_addr with req_addr of the granted requester; with no grant it holds the last granted address.
REQ-017 SHALL register rvalid: rvalid = gnt of the previous cycle (latency 1); rdata = mem_rdata passed through.
REQ-018 SHALL give host_we absolute priority: gnt = 0 in any cycle with host_we = 1; rr_ptr unchanged.
REQ-019 SHALL pass host_addr, host_wdata, host_we to mem_write_addr, mem_data_in, mem_write_en combinationally.
REQ-020 SHALL require requesters to hold req and req_addr stable until granted; req deasserted before grant is dropped silently.
REQ-021 SHALL allow back-to-back grants to the same requester only when no other req is asserted.
REQ-022 SHALL return data from the regfile as written before the edge on which the read is issued; a same-cycle host write to the read address is never concurrent with a read (REQ-018).
REQ-023 SHALL bound wait: a held request is granted within 4 grant cycles not blocked by host_we.

Reset
REQ-024 SHALL, on rst low, asynchronously clear rr_ptr to 0, rvalid to 0, mem_read_addr register to 0 and any stall counter to 0.
REQ-025 SHALL force gnt = 0 while rst is low; combinational write pass-through is unaffected.
REQ-026 SHALL discard a fetch in flight when reset asserts mid-operation: no rvalid after release.

Configuration
REQ-027 SHALL, with IMEM_ARB_STALL_CNT_EN defined, add output stall_cnt (16 bits): increments each cycle where req != 0 and gnt != req, saturates at 16'hFFFF, cleared by reset.
REQ-028 SHALL, without IMEM_ARB_STALL_CNT_EN, omit the stall_cnt port and counter logic; all other behaviour identical.

Verification
REQ-029 SHALL cover reset then req=4'b1111, fixed addrs 1,2,3,4 -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; rvalid follows 1 cycle later with mem_rdata of addrs 1,2,3,4.
REQ-030 SHALL cover host_we=1, host_addr=7, host_wdata=16'hA5A5 with req=4'b0011 -> gnt=0 that cycle, mem_write_en=1; next cycle requester 0 granted; fetch of addr 7 returns 16'hA5A5.
REQ-031 SHALL cover req=4'b0100 only for 3 cycles -> gnt=0100 each cycle, rvalid[2] high cycles 2-4.
REQ-032 SHALL cover rst low in the cycle after a grant -> rvalid stays 0, rr_ptr=0 after release, first grant goes to lowest asserted req.
REQ-033 SHALL cover, with IMEM_ARB_STALL_CNT_EN, req=4'b1111 for 10 cycles -> stall_cnt=10; forced near 16'hFFFF it holds at 16'hFFFF.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: four-way round-robin arbiter in front of a single-read-port
// instruction register file, with a host program-load write port that always
// wins over fetches.
// Optional build macro IMEM_ARB_STALL_CNT_EN adds a 16-bit saturating
// stall_cnt output counting cycles in which some request went unserved.
module imem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            gnt,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic [ADDR_W-1:0]     mem_read_addr,
  output logic [ADDR_W-1:0]     mem_write_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  output logic                  mem_write_en,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef IMEM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic [1:0]        rr_ptr;
  logic [1:0]        win_idx;
  logic              win_found;
  logic [3:0]        gnt_p0;
  logic              gnt_any_p0;
  logic [ADDR_W-1:0] rd_addr_p1;
  logic [3:0]        vld_p1;

  // Search requesters starting at rr_ptr, wrapping modulo 4; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && req[rr_ptr + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = rr_ptr + 2'(k);
      end
    end
  end

  // Issue the grant unless the host is loading or reset is held.
  always_comb begin
    gnt_p0 = '0;
    if (win_found && !host_we && rst) begin
      gnt_p0[win_idx] = 1'b1;
    end
  end

  assign gnt_any_p0 = |gnt_p0;
  assign gnt        = gnt_p0;

  // Read address follows the winner; between grants it parks on the last one.
  assign mem_read_addr = gnt_any_p0 ? req_addr[win_idx*ADDR_W +: ADDR_W] : rd_addr_p1;

  // Host writes bypass arbitration entirely, even during reset.
  assign mem_write_addr = host_addr;
  assign mem_data_in    = host_wdata;
  assign mem_write_en   = host_we;

  // ---- stage p0 -> p1: grant registered alongside the issued read ----

  // Advance the round-robin pointer past the winner on every grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 2'd0;
    end else if (gnt_any_p0) begin
      rr_ptr <= win_idx + 2'd1;
    end
  end

  // Remember the last granted address so the read port holds between grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_p1 <= '0;
    end else if (gnt_any_p0) begin
      rd_addr_p1 <= req_addr[win_idx*ADDR_W +: ADDR_W];
    end
  end

  // Delay the grant by one cycle to line up with the regfile read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= gnt_p0;
    end
  end

  assign rvalid = vld_p1;
  assign rdata  = mem_rdata;

`ifdef IMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count cycles where at least one request was left waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if ((|req) && (gnt_p0 != req)) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a behavioural regfile, a reference
// arbitration model, and a scoreboard of expected read returns.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [15:0] rdata;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [15:0] host_wdata;
  logic [4:0]  mem_read_addr;
  logic [4:0]  mem_write_addr;
  logic [15:0] mem_data_in;
  logic        mem_write_en;
  logic [15:0] mem_rdata;
`ifdef IMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  imem_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int          due;
    logic [3:0]  v;
    logic [15:0] d;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] ref_mem [32];
  logic [1:0]  rr_m;
  logic [4:0]  raddr_m;

  function automatic logic [15:0] init_word(int i);
    return 16'(32'hC000 + i * 37);
  endfunction

  // Behavioural regfile: preload once, write port, registered read.
  logic [15:0] mem [32];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_write_addr] <= mem_data_in;
    end
    mem_rdata <= mem[mem_read_addr];
  end

  // Scoreboard: every cycle either a queued return is due or rvalid is idle.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      x = sbq.pop_front();
      n_chk++;
      if (rvalid !== x.v || rdata !== x.d)
        $display("FAIL rdata_return cyc%0d: got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                 cyc, rvalid, rdata, x.v, x.d);
      else n_pass++;
    end else begin
      n_chk++;
      if (rvalid !== 4'b0000)
        $display("FAIL rvalid_idle cyc%0d: got %b want 0000", cyc, rvalid);
      else n_pass++;
    end
  end

  // Reference arbitration for the current cycle's inputs; queues the return.
  task automatic model_cycle(output logic [3:0] e, output logic [4:0] ea);
    logic [1:0] idx, k2;
    bit f;
    e = '0; f = 1'b0; idx = 2'd0;
    if (rst && !host_we) begin
      for (int k = 0; k < 4; k++) begin
        k2 = rr_m + 2'(k);
        if (!f && req[k2]) begin f = 1'b1; idx = k2; end
      end
    end
    if (f) begin
      e[idx]  = 1'b1;
      rr_m    = idx + 2'd1;
      raddr_m = req_addr[idx*5 +: 5];
      sbq.push_back('{cyc + 1, e, ref_mem[raddr_m]});
    end
    if (!rst) begin rr_m = 2'd0; raddr_m = '0; end
    if (host_we) ref_mem[host_addr] = host_wdata;
    ea = raddr_m;
  endtask

  task automatic set_addrs(input logic [4:0] a0, a1, a2, a3);
    req_addr = {a3, a2, a1, a0};
  endtask

  task automatic pulse_reset();
    rst = 1'b0; sbq.delete(); rr_m = 2'd0; raddr_m = '0;
    req = '0; host_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e; logic [4:0] ea;
    rst = 1'b0; sbq.delete();
    req = 4'b1111; set_addrs(5'd1, 5'd2, 5'd3, 5'd4);
    host_we = 1'b1; host_addr = 5'd3; host_wdata = 16'h1234;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (mem_read_addr !== 5'd0) $display("FAIL reset_raddr: got %0d want 0", mem_read_addr); else n_pass++;
    n_chk++; if (mem_write_en !== 1'b1 || mem_write_addr !== 5'd3 || mem_data_in !== 16'h1234)
      $display("FAIL reset_wr_pass: got we=%b a=%0d d=%h want we=1 a=3 d=1234", mem_write_en, mem_write_addr, mem_data_in);
    else n_pass++;
    @(posedge clk); #1;
    host_we = 1'b0; req = '0;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (rvalid !== 4'b0000) $display("FAIL reset_rvalid: got %b want 0000", rvalid); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] e; logic [4:0] ea;
    logic [3:0] tbl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [4:0] atb [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
    req = 4'b1111; set_addrs(5'd1, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); model_cycle(e, ea);
      n_chk++; if (gnt !== tbl[i]) $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, tbl[i]); else n_pass++;
      n_chk++; if (mem_read_addr !== atb[i]) $display("FAIL rr_raddr[%0d]: got %0d want %0d", i, mem_read_addr, atb[i]); else n_pass++;
      @(posedge clk); #1;
    end
    req = '0;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0000) $display("FAIL rr_idle_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (mem_read_addr !== 5'd1) $display("FAIL rr_hold_raddr: got %0d want 1", mem_read_addr); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_host_priority();
    logic [3:0] e; logic [4:0] ea;
    pulse_reset();
    req = 4'b0011; set_addrs(5'd7, 5'd9, 5'd0, 5'd0);
    host_we = 1'b1; host_addr = 5'd7; host_wdata = 16'hA5A5;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0000) $display("FAIL host_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (mem_write_en !== 1'b1 || mem_write_addr !== 5'd7 || mem_data_in !== 16'hA5A5)
      $display("FAIL host_wr_pass: got we=%b a=%0d d=%h want we=1 a=7 d=a5a5", mem_write_en, mem_write_addr, mem_data_in);
    else n_pass++;
    @(posedge clk); #1;
    host_we = 1'b0;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0001) $display("FAIL host_next_gnt: got %b want 0001", gnt); else n_pass++;
    n_chk++; if (mem_read_addr !== 5'd7) $display("FAIL host_next_raddr: got %0d want 7", mem_read_addr); else n_pass++;
    n_chk++; if (mem_write_en !== 1'b0) $display("FAIL host_we_off: got %b want 0", mem_write_en); else n_pass++;
    @(posedge clk); #1;
    req = 4'b0010;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0010) $display("FAIL host_then_r1: got %b want 0010", gnt); else n_pass++;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e; logic [4:0] ea;
    req = 4'b0100; set_addrs(5'd0, 5'd0, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_cycle(e, ea);
      n_chk++; if (gnt !== 4'b0100) $display("FAIL b2b_gnt[%0d]: got %b want 0100", i, gnt); else n_pass++;
      @(posedge clk); #1;
    end
    req = '0;
    @(negedge clk); model_cycle(e, ea);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] e; logic [4:0] ea;
    req = 4'b0010; set_addrs(5'd0, 5'd12, 5'd0, 5'd0);
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== e) $display("FAIL mid_pre_gnt: got %b want %b", gnt, e); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; sbq.delete(); req = 4'b1010;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (mem_read_addr !== 5'd0) $display("FAIL mid_rst_raddr: got %0d want 0", mem_read_addr); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); model_cycle(e, ea);
    n_chk++; if (gnt !== 4'b0010) $display("FAIL mid_first_gnt: got %b want 0010", gnt); else n_pass++;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_random();
    logic [3:0] e; logic [4:0] ea;
    for (int i = 0; i < 60; i++) begin
      req        = 4'($urandom_range(0, 15));
      req_addr   = 20'($urandom);
      host_we    = ($urandom_range(0, 4) == 0);
      host_addr  = 5'($urandom);
      host_wdata = 16'($urandom);
      @(negedge clk); model_cycle(e, ea);
      n_chk++; if (gnt !== e) $display("FAIL rand_gnt[%0d]: got %b want %b", i, gnt, e); else n_pass++;
      n_chk++; if (mem_read_addr !== ea) $display("FAIL rand_raddr[%0d]: got %0d want %0d", i, mem_read_addr, ea); else n_pass++;
      n_chk++; if (mem_write_en !== host_we || mem_write_addr !== host_addr)
        $display("FAIL rand_wr[%0d]: got we=%b a=%0d want we=%b a=%0d", i, mem_write_en, mem_write_addr, host_we, host_addr);
      else n_pass++;
      @(posedge clk); #1;
    end
    req = '0; host_we = 1'b0;
    @(negedge clk); model_cycle(e, ea);
    @(posedge clk); #1;
  endtask

`ifdef IMEM_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    logic [3:0] e; logic [4:0] ea;
    pulse_reset();
    req = 4'b1111; set_addrs(5'd1, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); model_cycle(e, ea);
      @(posedge clk); #1;
    end
    n_chk++; if (stall_cnt !== 16'd10) $display("FAIL stall_10: got %0d want 10", stall_cnt); else n_pass++;
    for (int i = 0; i < 65530; i++) begin
      @(negedge clk); model_cycle(e, ea);
      @(posedge clk); #1;
    end
    n_chk++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_sat: got %h want ffff", stall_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); model_cycle(e, ea);
      @(posedge clk); #1;
    end
    n_chk++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_hold: got %h want ffff", stall_cnt); else n_pass++;
    req = '0;
    @(negedge clk); model_cycle(e, ea);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    rr_m = 2'd0; raddr_m = '0;
    rst = 1'b1; req = '0; req_addr = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #2;
    test_reset();
    test_round_robin();
    test_host_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef IMEM_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
